// File: rtl/spi_peripheral.sv
// SPI mode-0 (CPOL=0, CPHA=0), MSB-first peripheral.
// SCLK, MOSI and CS are oversampled in the clk domain. Each completed word is presented on rx_data.
// The reply word comes from a one-entry transmit holding register and is shifted out on SPI_MISO.
//
// state  | meaning
// IDLE   | synchronized CS high; SCLK ignored, SPI_MISO low, bit counter held at 0
// ACTIVE | synchronized CS low; shifting words, multi-word frames while CS stays low
module spi_peripheral #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SPI_SCLK,
    input  logic                  SPI_MOSI,
    input  logic                  SPI_CS,
    output logic                  SPI_MISO,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_wr,
    output logic                  tx_full,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, mosi_s, cs_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic                   byte_done, load;

    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_rx, shift_tx, tx_hold;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    // The counter parks at DATA_WIDTH for exactly one cycle after the last rising edge.
    // That cycle delivers the word and, while CS is still low, reloads the transmit shifter.
    assign byte_done = (state == ACTIVE) && (bit_cnt == CNT_FULL);
    assign load      = ((state == IDLE) && cs_fall) || (byte_done && !cs_rise);

    assign busy = ~cs_s;

    // Input synchronizers plus one edge-detect stage; CS idles high so reset does not fake a falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic, following the synchronized chip select.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (cs_fall) next_state = ACTIVE;
            ACTIVE:  if (cs_rise) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Holding register: the last write wins. A write in a load cycle keeps the new value pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_hold <= '0;
            tx_full <= 1'b0;
        end else if (tx_wr) begin
            tx_hold <= tx_data;
            tx_full <= 1'b1;
        end else if (load && tx_full) begin
            tx_full <= 1'b0;
        end
    end

    // Shift datapath: sample MOSI on SCLK rise, advance MISO on SCLK fall, deliver and reload per word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            SPI_MISO    <= 1'b0;
            bit_cnt     <= '0;
            shift_rx    <= '0;
            shift_tx    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;

            if (state == ACTIVE) begin
                if (cs_rise) begin
                    if (bit_cnt != '0 && bit_cnt != CNT_FULL) begin
                        frame_err <= 1'b1;
                    end
                    if (byte_done) begin
                        rx_data  <= shift_rx;
                        rx_valid <= 1'b1;
                    end
                    bit_cnt  <= '0;
                    SPI_MISO <= 1'b0;
                end else if (byte_done) begin
                    rx_data  <= shift_rx;
                    rx_valid <= 1'b1;
                    bit_cnt  <= '0;
                end else if (sclk_rise) begin
                    shift_rx <= {shift_rx[DATA_WIDTH-2:0], mosi_s};
                    bit_cnt  <= bit_cnt + CNT_ONE;
                end else if (sclk_fall && bit_cnt != '0) begin
                    // The fall that follows the last rise sees a count of 0 and leaves the freshly loaded MSB alone.
                    shift_tx <= {shift_tx[DATA_WIDTH-2:0], 1'b0};
                    SPI_MISO <= shift_tx[DATA_WIDTH-2];
                end
            end

            if (load) begin
                if (tx_full) begin
                    shift_tx <= tx_hold;
                    SPI_MISO <= tx_hold[DATA_WIDTH-1];
                end else begin
                    shift_tx    <= '0;
                    SPI_MISO    <= 1'b0;
                    tx_underrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: the bench plays the SPI controller itself.
// Inputs are driven on the falling clk edge, and DUT outputs are sampled there too.
module tb_spi_peripheral;

    localparam int HALF = 8;  // SCLK half-period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       SPI_SCLK = 1'b0;
    logic       SPI_MOSI = 1'b0;
    logic       SPI_CS = 1'b1;
    logic       SPI_MISO;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0;
    logic       tx_full;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       frame_err;
    logic       busy;

    int n_vec = 0;
    int n_bad = 0;
    int n_rxv = 0;
    int n_und = 0;
    int n_ferr = 0;

    spi_peripheral #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .SPI_SCLK    (SPI_SCLK),
        .SPI_MOSI    (SPI_MOSI),
        .SPI_CS      (SPI_CS),
        .SPI_MISO    (SPI_MISO),
        .tx_data     (tx_data),
        .tx_wr       (tx_wr),
        .tx_full     (tx_full),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Pulse counters for the one-cycle status strobes.
    always @(negedge clk) begin
        if (rx_valid)    n_rxv  = n_rxv + 1;
        if (tx_underrun) n_und  = n_und + 1;
        if (frame_err)   n_ferr = n_ferr + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_wr(input logic [7:0] v);
        tx_data = v;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr   = 1'b0;
    endtask

    task automatic cs_low();
        SPI_CS = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        SPI_CS = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // Clocks out nbits of b MSB-first. MISO is captured just before each rising edge.
    // With wr_at_load set, tx_wr is pulsed in the word-complete load cycle after the 8th rise.
    task automatic spi_bits(input logic [7:0] b, input int nbits, input bit wr_at_load,
                            input logic [7:0] wr_val, output logic [7:0] got);
        got = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            SPI_MOSI = b[i];
            repeat (HALF) @(negedge clk);
            got[i]   = SPI_MISO;
            SPI_SCLK = 1'b1;
            if (i == 0 && wr_at_load) begin
                repeat (3) @(negedge clk);
                tx_data = wr_val;
                tx_wr   = 1'b1;
                @(negedge clk);
                tx_wr   = 1'b0;
                repeat (HALF - 4) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            SPI_SCLK = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] got;
        int r0, u0, f0;

        repeat (3) @(negedge clk);
        check_eq("rst_miso", SPI_MISO, 1'b0);
        check_eq("rst_tx_full", tx_full, 1'b0);
        check_eq("rst_rx_data", rx_data, 8'h00);
        check_eq("rst_pulses", {rx_valid, tx_underrun, frame_err}, 3'b000);
        check_eq("rst_busy", busy, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single word, 0xA5 returned while 0x3C is received
        do_wr(8'hA5);
        check_eq("t1_full_set", tx_full, 1'b1);
        r0 = n_rxv; u0 = n_und; f0 = n_ferr;
        cs_low();
        check_eq("t1_full_clr", tx_full, 1'b0);
        check_eq("t1_no_underrun", n_und - u0, 0);
        check_eq("t1_busy", busy, 1'b1);
        spi_bits(8'h3C, 8, 1'b0, 8'h00, got);
        check_eq("t1_miso_word", got, 8'hA5);
        check_eq("t1_rx_data", rx_data, 8'h3C);
        check_eq("t1_rx_valid_cnt", n_rxv - r0, 1);
        cs_high();
        check_eq("t1_no_frame_err", n_ferr - f0, 0);
        check_eq("t1_busy_end", busy, 1'b0);

        // 2: three-word frame with CS held low
        do_wr(8'h11);
        r0 = n_rxv; u0 = n_und;
        cs_low();
        do_wr(8'h22);
        spi_bits(8'hC0, 8, 1'b0, 8'h00, got);
        check_eq("t2_w0_miso", got, 8'h11);
        check_eq("t2_w0_rx", rx_data, 8'hC0);
        do_wr(8'h33);
        spi_bits(8'hDE, 8, 1'b0, 8'h00, got);
        check_eq("t2_w1_miso", got, 8'h22);
        check_eq("t2_w1_rx", rx_data, 8'hDE);
        check_eq("t2_no_underrun", n_und - u0, 0);
        spi_bits(8'h55, 8, 1'b0, 8'h00, got);
        check_eq("t2_w2_miso", got, 8'h33);
        check_eq("t2_w2_rx", rx_data, 8'h55);
        check_eq("t2_rx_valid_cnt", n_rxv - r0, 3);
        check_eq("t2_busy", busy, 1'b1);
        cs_high();

        // 3: empty holding register at frame start
        u0 = n_und;
        cs_low();
        check_eq("t3_underrun", n_und - u0, 1);
        spi_bits(8'h7E, 8, 1'b0, 8'h00, got);
        check_eq("t3_miso_word", got, 8'h00);
        check_eq("t3_rx", rx_data, 8'h7E);
        cs_high();

        // 4: partial word aborted by CS, then a clean word
        r0 = n_rxv; f0 = n_ferr;
        cs_low();
        spi_bits(8'hB0, 4, 1'b0, 8'h00, got);
        cs_high();
        check_eq("t4_frame_err", n_ferr - f0, 1);
        check_eq("t4_no_rx_valid", n_rxv - r0, 0);
        check_eq("t4_rx_held", rx_data, 8'h7E);
        cs_low();
        spi_bits(8'h96, 8, 1'b0, 8'h00, got);
        cs_high();
        check_eq("t4_rx", rx_data, 8'h96);
        check_eq("t4_frame_err_once", n_ferr - f0, 1);

        // 5: asynchronous reset after the 3rd bit
        do_wr(8'h77);
        r0 = n_rxv;
        cs_low();
        do_wr(8'h55);
        spi_bits(8'h5A, 3, 1'b0, 8'h00, got);
        check_eq("t5_miso_pre", SPI_MISO, 1'b1);
        rst    = 1'b0;
        SPI_CS = 1'b1;
        @(negedge clk);
        check_eq("t5_rst_miso", SPI_MISO, 1'b0);
        check_eq("t5_rst_full", tx_full, 1'b0);
        check_eq("t5_rst_rx", rx_data, 8'h00);
        check_eq("t5_rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        do_wr(8'h0F);
        cs_low();
        spi_bits(8'hF0, 8, 1'b0, 8'h00, got);
        cs_high();
        check_eq("t5_miso_word", got, 8'h0F);
        check_eq("t5_rx", rx_data, 8'hF0);
        check_eq("t5_rx_valid_cnt", n_rxv - r0, 1);

        // 6: overwrite before the frame, then a write in the load cycle
        do_wr(8'h01);
        do_wr(8'h02);
        u0 = n_und;
        cs_low();
        spi_bits(8'h12, 8, 1'b1, 8'h03, got);
        check_eq("t6_w0_miso", got, 8'h02);
        check_eq("t6_load_underrun", n_und - u0, 1);
        check_eq("t6_full_kept", tx_full, 1'b1);
        spi_bits(8'h34, 8, 1'b0, 8'h00, got);
        check_eq("t6_w1_miso", got, 8'h00);
        check_eq("t6_full_clr", tx_full, 1'b0);
        spi_bits(8'h56, 8, 1'b0, 8'h00, got);
        check_eq("t6_w2_miso", got, 8'h03);
        check_eq("t6_rx", rx_data, 8'h56);
        cs_high();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
